// File: rtl/seg7_pkg.sv
// Shared display constants and digit-index type for the scan controller, selector and decoder.
// Latency: none (types and constants only).
// Backpressure: not applicable.
package seg7_pkg;

    localparam int DIGITS = 4;
    localparam logic [DIGITS-1:0] AN_OFF = 4'b1111;

    typedef logic [1:0] digit_t;

    localparam digit_t LAST_DIGIT = 2'd3;

    // Active-low one-hot anode pattern that lights digit d.
    function automatic logic [DIGITS-1:0] an_onehot_low(digit_t d);
        return ~(4'b0001 << d);
    endfunction

endpackage

// File: rtl/seg7_slot_timer.sv
// Per-digit slot counter; flags the last cycle of a slot and the blanking window of the next state.
// Latency: slot_end/in_blank are combinational from the registered count (and en).
// Backpressure: none; en low synchronously clears the count.
module seg7_slot_timer #(
    parameter int DIV   = 50000,
    parameter int BLANK = 500
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    output logic slot_end,
    output logic in_blank
);

    localparam int CW = $clog2(DIV);
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    generate
        if (DIV < 2 || BLANK < 0 || BLANK >= DIV) begin : g_bad_params
            $error("seg7_slot_timer: need DIV >= 2 and 0 <= BLANK < DIV (DIV=%0d BLANK=%0d)", DIV, BLANK);
        end
    endgenerate

    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_next;

    always_comb begin
        cnt_next = '0;
        if (en && cnt != LAST) begin
            cnt_next = cnt + CW'(1);
        end
    end

    assign slot_end = (cnt == LAST);

    // Blanking is judged on the count that will be presented after this edge.
    generate
        if (BLANK == 0) begin : g_no_blank
            assign in_blank = 1'b0;
        end else begin : g_blank
            localparam logic [CW-1:0] BL = CW'(BLANK);
            assign in_blank = (cnt_next < BL);
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else begin
            cnt <= cnt_next;
        end
    end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// 4-digit common-anode scan controller: digit select, active-low anodes with slot blanking, frame pulse.
// Latency: all outputs registered; AN reflects the SW/slot state presented in the same cycle.
// Backpressure: none; EN low darkens the display and parks the scan at digit 0.
module seg7_scan_ctrl
    import seg7_pkg::*;
#(
    parameter int DIV   = 50000,
    parameter int BLANK = 500
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        EN,
    input  logic [3:0]  ENA,
    output logic [1:0]  SW,
    output logic [3:0]  AN,
    output logic        FRAME
);

    logic   slot_end;
    logic   in_blank;
    digit_t sw_q;
    digit_t sw_next;
    logic [DIGITS-1:0] an_next;
    logic   frame_next;

    seg7_slot_timer #(
        .DIV   (DIV),
        .BLANK (BLANK)
    ) u_slot_timer (
        .clk      (CLK),
        .rst_n    (RST_N),
        .en       (EN),
        .slot_end (slot_end),
        .in_blank (in_blank)
    );

    // EN low overrides a coincident slot wrap: digit 0, no frame pulse.
    always_comb begin
        sw_next    = '0;
        frame_next = 1'b0;
        an_next    = AN_OFF;
        if (EN) begin
            sw_next    = slot_end ? digit_t'(sw_q + 2'd1) : sw_q;
            frame_next = slot_end && (sw_q == LAST_DIGIT);
            if (!in_blank && ENA[sw_next]) begin
                an_next = an_onehot_low(sw_next);
            end
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            sw_q  <= '0;
            AN    <= AN_OFF;
            FRAME <= 1'b0;
        end else begin
            sw_q  <= sw_next;
            AN    <= an_next;
            FRAME <= frame_next;
        end
    end

    assign SW = sw_q;

endmodule

// File: doc/seg7_scan_ctrl.md
Name: seg7_scan_ctrl

Overview:
- Time-multiplexing scan controller for the 4-digit common-anode 7-segment display.
- Drives the 2-bit digit select SW into the digit selector, which picks one of CNT1..CNT4 for the segment decoder.
- Drives the matching active-low anode line AN.
- Inserts a programmable blanking interval at the start of each digit slot to suppress ghosting, and flags each completed frame.

Parameters:
- DIV, 50000, clock cycles per digit slot; legal range DIV >= 2.
- BLANK, 500, cycles at the start of each slot during which all anodes are off; legal range 0 <= BLANK < DIV.

Ports:
- CLK  input  1  system clock; all state updates on the rising edge.
- RST_N  input  1  asynchronous active-low reset.
- EN  input  1  scan enable; when low, the display is dark and the scan is held at digit 0.
- ENA  input  4  per-digit enable; bit i=1 lets digit i light. Used for leading-zero suppression.
- SW  output  2  current digit index, 0..3; feeds the digit selector's select input.
- AN  output  4  anodes, active-low, one-hot-low when lit, 4'b1111 when dark.
- FRAME  output  1  one-cycle pulse when the scan wraps from digit 3 to digit 0.

Behaviour:
- Reset is asynchronous and active-low: RST_N=0 immediately forces the following, regardless of CLK:
  - internal slot counter cnt=0
  - SW=2'b00
  - AN=4'b1111
  - FRAME=0
- All outputs are registered; there is no combinational path from any input to any output.
- Slot counter cnt, width clog2(DIV). On each rising edge with EN=1:
  - if cnt==DIV-1: cnt<=0 and SW<=SW+1 (mod 4, 3 wraps to 0)
  - else: cnt<=cnt+1
- FRAME<=1 on the edge where SW goes 3->0; otherwise FRAME<=0.
- AN is computed from next-state values on the same edge, so AN is always consistent with the SW and cnt presented in that cycle:
  - AN<=4'b1111 if EN=0, or cnt_next<BLANK, or ENA[SW_next]=0
  - otherwise AN<=~(4'b0001<<SW_next)
- ENA is sampled every edge; a change takes effect on the next edge, including mid-slot.
- EN=0 on an edge is a synchronous clear: cnt<=0, SW<=0, AN<=4'b1111, FRAME<=0.
- When EN returns to 1, the scan restarts at digit 0, cnt=0 state, as after reset.
- BLANK=0: no blanking; the digit is lit for the full DIV cycles of its slot.
- Slot timing: each digit is lit for exactly DIV-BLANK cycles per slot. One frame is 4*DIV cycles.
- Reset asserted mid-slot: outputs go to reset values immediately. The scan restarts from digit 0 after release.
- Simultaneous EN falling and slot wrap on the same edge: EN wins; SW=0 and FRAME=0.
- Out-of-range parameters are not supported; the implementation includes a simulation-time check that errors on DIV<2 or BLANK>=DIV.

Decomposition:
- Shared package seg7_pkg:
  - constant DIGITS=4
  - constant AN_OFF=4'b1111
  - 2-bit digit-index typedef, also used by the selector and decoder
- One natural sub-module: seg7_slot_timer. It holds the cnt register and produces slot_end (cnt==DIV-1) and in_blank (cnt_next<BLANK), with synchronous clear on EN=0.
- Top-level holds the SW, AN and FRAME registers and the anode decode.

Test Plan (DIV=4, BLANK=1 unless stated):
- Reset check:
  - Stimulus: RST_N low mid-scan, asserted between clock edges.
  - Response: SW=0, AN=1111 and FRAME=0 immediately, before the next edge.
- Basic scan (ENA=1111, EN=1 after reset):
  - edges 1-3: SW=0, AN=1110
  - edge 4: SW=1, AN=1111
  - edges 5-7: AN=1101
  - continue through digits 2 and 3
  - edge 16: SW=0, AN=1111, FRAME=1 for exactly one cycle
  - FRAME repeats every 16 cycles
- No blanking:
  - Stimulus: BLANK=0, DIV=2.
  - Response: AN sequence 1110,1110,1101,1101,1011,1011,0111,0111, repeating; AN is never 1111 while EN=1 after the first edge.
- Digit suppression:
  - Stimulus: ENA=0011.
  - Response: AN=1111 throughout the slots with SW=2 and SW=3; SW still steps 0..3; the FRAME period is unchanged.
  - Stimulus: ENA changes to 1111 mid-slot.
  - Response: that digit lights on the next edge.
- EN clear:
  - Stimulus: drop EN at SW=2, cnt=2 for 3 cycles.
  - Response: from the next edge SW=0, AN=1111, FRAME=0.
  - Stimulus: restore EN.
  - Response: the first edge gives SW=0, AN=1110.
- Wrap collision:
  - Stimulus: EN falls on the edge where SW would go 3->0.
  - Response: SW=0, FRAME stays 0.
